// File: rtl/pool_line_tx.sv
// Pooled-line transmitter: snapshots the three channel line vectors when a pooled
// line completes and streams the 9 bytes over a valid/ready byte interface.
//
// state  | meaning
// IDLE   | no line pending, out_vld low, waiting for a capture event
// SEND   | line buffered, streaming bytes idx 0..8 under out_rdy backpressure
module pool_line_tx #(
  parameter int CNT_W   = 7,
  parameter int CAP_CNT = 68
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_vld,
  input  logic [CNT_W-1:0] cnt,
  input  logic [23:0]      pool_lin_D1,
  input  logic [23:0]      pool_lin_D2,
  input  logic [23:0]      pool_lin_D3,
  output logic [7:0]       out_data,
  output logic             out_vld,
  input  logic             out_rdy,
  output logic             out_last,
  output logic [3:0]       out_idx,
  output logic             ovf,
  input  logic             ovf_clr
);

  localparam int         NBYTE    = 9;
  localparam logic [3:0] LAST_IDX = 4'(NBYTE - 1);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_SEND = 1'b1;

  logic [0:0]         state;
  logic [8*NBYTE-1:0] shadow;
  logic [3:0]         idx;
  logic               cap_ev;
  logic               xfer;
  logic               last_xfer;
  logic               drop;

  assign cap_ev    = in_vld && (cnt == CNT_W'(CAP_CNT));
  assign xfer      = out_vld && out_rdy;
  assign last_xfer = xfer && (idx == LAST_IDX);
  // A capture only fits if the previous line drains on that very edge.
  assign drop      = (state == S_SEND) && cap_ev && !last_xfer;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      shadow  <= '0;
      idx     <= '0;
      out_vld <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cap_ev) begin
            shadow  <= {pool_lin_D3, pool_lin_D2, pool_lin_D1};
            idx     <= '0;
            out_vld <= 1'b1;
            state   <= S_SEND;
          end
        end
        S_SEND: begin
          if (last_xfer) begin
            idx <= '0;
            if (cap_ev) begin
              shadow <= {pool_lin_D3, pool_lin_D2, pool_lin_D1};
            end else begin
              out_vld <= 1'b0;
              state   <= S_IDLE;
            end
          end else if (xfer) begin
            idx <= idx + 4'd1;
          end
        end
        default: begin
          state   <= S_IDLE;
          idx     <= '0;
          out_vld <= 1'b0;
        end
      endcase

      if (drop) begin
        ovf <= 1'b1;
      end else if (ovf_clr) begin
        ovf <= 1'b0;
      end
    end
  end

  // Output byte is a mux of registered state, so it is stable while stalled.
  always_comb begin
    out_data = 8'h00;
    for (int k = 0; k < NBYTE; k++) begin
      if (idx == 4'(k)) begin
        out_data = shadow[8*k +: 8];
      end
    end
  end

  assign out_idx  = idx;
  assign out_last = out_vld && (idx == LAST_IDX);

endmodule

// File: tb/tb_pool_line_tx.sv
// Directed bench for pool_line_tx: vector table plus hand sequences for
// back-to-back capture and reset mid-line.
module tb_pool_line_tx;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_vld;
  logic [6:0]  cnt;
  logic [23:0] d1, d2, d3;
  logic [7:0]  out_data;
  logic        out_vld;
  logic        out_rdy;
  logic        out_last;
  logic [3:0]  out_idx;
  logic        ovf;
  logic        ovf_clr;

  int n_tests = 0;
  int n_fail  = 0;

  pool_line_tx #(.CNT_W(7), .CAP_CNT(68)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_vld     (in_vld),
    .cnt        (cnt),
    .pool_lin_D1(d1),
    .pool_lin_D2(d2),
    .pool_lin_D3(d3),
    .out_data   (out_data),
    .out_vld    (out_vld),
    .out_rdy    (out_rdy),
    .out_last   (out_last),
    .out_idx    (out_idx),
    .ovf        (ovf),
    .ovf_clr    (ovf_clr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       iv;
    logic [6:0] cnt;
    int         ds;
    logic       rdy;
    logic       clr;
    logic       ev;
    logic [7:0] ed;
    logic [3:0] ei;
    logic       el;
    logic       eo;
  } vec_t;

  vec_t tab[$];

  function automatic vec_t mk(int r, int iv, int c, int ds, int rdy, int clr,
                              int ev, int ed, int ei, int el, int eo);
    vec_t v;
    v.rst = 1'(r);   v.iv  = 1'(iv);  v.cnt = 7'(c);  v.ds = ds;
    v.rdy = 1'(rdy); v.clr = 1'(clr); v.ev  = 1'(ev); v.ed = 8'(ed);
    v.ei  = 4'(ei);  v.el  = 1'(el);  v.eo  = 1'(eo);
    return v;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // ds 0 = line A (bytes 01..09), ds 1 = line B (bytes 11..19)
  task automatic step(int r, int iv, int c, int ds, int rdy, int clr);
    rst     = 1'(r);
    in_vld  = 1'(iv);
    cnt     = 7'(c);
    out_rdy = 1'(rdy);
    ovf_clr = 1'(clr);
    if (ds == 0) begin
      d1 = 24'h030201; d2 = 24'h060504; d3 = 24'h090807;
    end else begin
      d1 = 24'h131211; d2 = 24'h161514; d3 = 24'h191817;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(string nm, int ev, int ed, int ei, int el, int eo,
                            int chk_data);
    chk({nm, ".vld"}, 32'(out_vld), 32'(ev));
    chk({nm, ".idx"}, 32'(out_idx), 32'(ei));
    chk({nm, ".last"}, 32'(out_last), 32'(el));
    chk({nm, ".ovf"}, 32'(ovf), 32'(eo));
    if (chk_data != 0) chk({nm, ".data"}, 32'(out_data), 32'(ed));
  endtask

  initial begin
    int pat[14] = '{1, 0, 0, 1, 0, 1, 1, 0, 1, 1, 0, 1, 1, 1};
    int k;

    rst = 1'b1; in_vld = 1'b0; cnt = '0; out_rdy = 1'b0; ovf_clr = 1'b0;
    d1 = '0; d2 = '0; d3 = '0;

    // reset, then basic line at full rate; D inputs switch to B while sending
    tab.push_back(mk(1, 0, 0, 0, 0, 0, 0, 8'h00, 0, 0, 0));
    tab.push_back(mk(0, 1, 68, 0, 1, 0, 1, 8'h01, 0, 0, 0));
    for (int i = 1; i <= 8; i++)
      tab.push_back(mk(0, 0, 0, 1, 1, 0, 1, i + 1, i, (i == 8) ? 1 : 0, 0));
    tab.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
    // non-capture filtering
    tab.push_back(mk(0, 0, 68, 0, 1, 0, 0, 0, 0, 0, 0));
    tab.push_back(mk(0, 1, 67, 0, 1, 0, 0, 0, 0, 0, 0));
    tab.push_back(mk(0, 1, 69, 0, 1, 0, 0, 0, 0, 0, 0));
    tab.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
    // backpressure: captured with rdy low, then an irregular ready pattern
    tab.push_back(mk(0, 1, 68, 0, 0, 0, 1, 8'h01, 0, 0, 0));
    k = 0;
    for (int i = 0; i < 14; i++) begin
      k += pat[i];
      if (k < 9) tab.push_back(mk(0, 0, 0, i % 2, pat[i], 0, 1, k + 1, k, (k == 8) ? 1 : 0, 0));
      else       tab.push_back(mk(0, 0, 0, i % 2, pat[i], 0, 0, 0, 0, 0, 0));
    end
    // overflow: drop while stalled on byte 1, original line still delivered
    tab.push_back(mk(0, 1, 68, 0, 0, 0, 1, 8'h01, 0, 0, 0));
    tab.push_back(mk(0, 0, 0, 0, 1, 0, 1, 8'h02, 1, 0, 0));
    tab.push_back(mk(0, 1, 68, 1, 0, 0, 1, 8'h02, 1, 0, 1));
    tab.push_back(mk(0, 0, 0, 1, 0, 0, 1, 8'h02, 1, 0, 1));
    for (int i = 2; i <= 8; i++)
      tab.push_back(mk(0, 0, 0, 1, 1, 0, 1, i + 1, i, (i == 8) ? 1 : 0, 1));
    tab.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1));
    tab.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
    tab.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    // set and clear together: set wins, then a lone clear
    tab.push_back(mk(0, 1, 68, 0, 0, 0, 1, 8'h01, 0, 0, 0));
    tab.push_back(mk(0, 1, 68, 1, 0, 1, 1, 8'h01, 0, 0, 1));
    tab.push_back(mk(0, 0, 0, 0, 0, 1, 1, 8'h01, 0, 0, 0));
    for (int i = 1; i <= 8; i++)
      tab.push_back(mk(0, 0, 0, 0, 1, 0, 1, i + 1, i, (i == 8) ? 1 : 0, 0));
    tab.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));

    for (int i = 0; i < tab.size(); i++) begin
      step(tab[i].rst, tab[i].iv, tab[i].cnt, tab[i].ds, tab[i].rdy, tab[i].clr);
      expect_out($sformatf("vec%0d", i), tab[i].ev, tab[i].ed, tab[i].ei, tab[i].el,
                 tab[i].eo, (tab[i].ev || tab[i].rst) ? 1 : 0);
    end

    // back-to-back: line B captured on the 9th-byte handshake of line A
    step(0, 1, 68, 0, 1, 0);
    expect_out("b2b.first", 1, 8'h01, 0, 0, 0, 1);
    for (int i = 1; i <= 8; i++) step(0, 0, 0, 0, 1, 0);
    expect_out("b2b.lastA", 1, 8'h09, 8, 1, 0, 1);
    step(0, 1, 68, 1, 1, 0);
    expect_out("b2b.firstB", 1, 8'h11, 0, 0, 0, 1);
    for (int i = 1; i <= 8; i++) begin
      step(0, 0, 0, 0, 1, 0);
      expect_out($sformatf("b2b.B%0d", i), 1, 8'h11 + i, i, (i == 8) ? 1 : 0, 0, 1);
    end
    step(0, 0, 0, 0, 1, 0);
    expect_out("b2b.end", 0, 0, 0, 0, 0, 0);

    // reset mid-line: force ovf first, accept 4 bytes, then reset
    step(0, 1, 68, 0, 0, 0);
    step(0, 1, 68, 1, 0, 0);
    expect_out("rstmid.ovf", 1, 8'h01, 0, 0, 1, 1);
    for (int i = 1; i <= 4; i++) step(0, 0, 0, 0, 1, 0);
    expect_out("rstmid.before", 1, 8'h05, 4, 0, 1, 1);
    step(1, 0, 0, 0, 1, 0);
    expect_out("rstmid.rst", 0, 8'h00, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1, 0);
    expect_out("rstmid.idle", 0, 0, 0, 0, 0, 0);
    step(0, 1, 68, 1, 1, 0);
    expect_out("rstmid.restart", 1, 8'h11, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1, 0);
    expect_out("rstmid.next", 1, 8'h12, 1, 0, 0, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pool_line_tx.md
Name: pool_line_tx

Overview:
- Reader/transmitter on the output side of the three-channel 2x2 pooling unit.
- Monitors the pooling unit's in_vld/cnt sequence and snapshots the three 24-bit pooled line vectors (3 channels x 3 bytes) when a pooled line completes.
- Serialises the 9 bytes over a valid/ready byte stream to the downstream flatten/FC stage.
- Flags a dropped line if the next line completes before the current one has been fully sent.

Parameters:
- CNT_W, 7, width of cnt; equals $clog2(69).
- CAP_CNT, 68, cnt value at which, with in_vld=1, the pooled line vectors are final and must be captured.
- NBYTE, 9, bytes per line (3 channels x 3 bytes); fixed, not for override.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- in_vld  in  1  same in_vld that drives the pooling unit.
- cnt  in  CNT_W  same cnt that drives the pooling unit.
- pool_lin_D1  in  24  channel-1 pooled line; byte k = bits [8k+7:8k].
- pool_lin_D2  in  24  channel-2 pooled line.
- pool_lin_D3  in  24  channel-3 pooled line.
- out_data  out  8  current stream byte.
- out_vld  out  1  out_data valid.
- out_rdy  in  1  downstream ready; a byte transfers when out_vld & out_rdy.
- out_last  out  1  high with the 9th byte of a line.
- out_idx  out  4  index 0..8 of the current byte.
- ovf  out  1  sticky overflow: a line was dropped.
- ovf_clr  in  1  clears ovf (synchronous).

Behaviour:
- Reset: synchronous, active-high, sampled on the rising edge of clk.
  - Outputs: out_vld=0, out_last=0, out_idx=0, out_data=0, ovf=0.
  - State: IDLE. Shadow buffer: 0.
- cap_ev = in_vld & (cnt == CAP_CNT), evaluated combinationally each cycle.
- Shadow buffer: 72 bits, loaded as {D3,D2,D1}.
- Byte order: D1[7:0], D1[15:8], D1[23:16], D2[7:0], ..., D3[23:16] (idx 0..8).
- FSM has two states, IDLE and SEND.
  - IDLE, cap_ev: load buffer, idx<=0, out_vld<=1, go to SEND. First byte is visible the cycle after the capture edge (latency 1).
  - IDLE, no cap_ev: hold. out_vld=0.
  - SEND, out_vld & out_rdy & idx<8: idx<=idx+1. out_vld stays 1.
  - SEND, out_vld & out_rdy & idx==8 (last byte accepted), no cap_ev: out_vld<=0, idx<=0, go to IDLE.
  - SEND, last byte accepted and cap_ev in the same cycle: reload buffer, idx<=0, stay in SEND with out_vld=1. No bubble and no overflow.
  - SEND, cap_ev and not (last byte accepted): capture is ignored. Buffer and idx are unchanged and ovf<=1.
  - SEND, out_rdy=0: out_data, out_idx and out_last hold. out_vld is never withdrawn once asserted until the byte transfers.
- out_data = buffer byte selected by idx, registered or from a registered mux. It must be stable while out_vld=1 and out_rdy=0.
- out_last = out_vld & (idx==8).
- ovf:
  - Set by a dropped capture; stays set.
  - Cleared only by rst or ovf_clr.
  - If set and clear occur in the same cycle, set wins.
- pool_lin_D* are sampled only on cap_ev. Changes at any other time have no effect.
- cnt values other than CAP_CNT and in_vld=0 cycles have no effect.
- Reset asserted mid-line aborts the transfer. The next cycle has out_vld=0 and a partial line is never resumed.

Test Plan:
- Basic line: D1=0x030201, D2=0x060504, D3=0x090807, in_vld=1 with cnt=68, out_rdy=1 -> from the next cycle, 9 consecutive beats with out_data 0x01..0x09, out_idx 0..8, out_last only on 0x09, then out_vld=0. ovf=0.
- Backpressure: same line, out_rdy toggling 1,0,0,1,... -> each byte is held stable while out_rdy=0. Byte order and count are unchanged, exactly 9 transfers.
- Back-to-back: second cap_ev (D1=0x131211, D2=0x161514, D3=0x191817) in the same cycle as the 9th-byte handshake -> next cycle out_data=0x11, idx=0, no idle cycle, ovf=0.
- Overflow: out_rdy=0 after the first byte, then a second cap_ev -> ovf=1, and the stream still delivers the original bytes 0x02..0x09. ovf_clr pulse drops ovf to 0, while ovf_clr held together with a new drop keeps ovf=1.
- Non-capture filtering: cnt=68 with in_vld=0, and cnt=67 with in_vld=1 -> out_vld stays 0.
- Reset mid-line: rst=1 after 4 bytes accepted -> next cycle out_vld=0, idx=0, ovf=0. A later capture restarts from idx 0.
